// File: rtl/trans_arbiter.sv
// trans_arbiter: round-robin arbiter for two search clients in front of the trans table.
// It turns each granted request into a held level strobe, waits on trans busy and returns a one-cycle response.
module trans_arbiter #(
  parameter int BOARD_WIDTH   = 256,
  parameter int EVAL_WIDTH    = 16,
  parameter int ISSUE_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_store,
  input  logic [BOARD_WIDTH-1:0] req_board_0,
  input  logic [BOARD_WIDTH-1:0] req_board_1,
  input  logic [1:0]             req_white_to_move,
  input  logic [3:0]             req_castle_mask_0,
  input  logic [3:0]             req_castle_mask_1,
  input  logic [3:0]             req_en_passant_col_0,
  input  logic [3:0]             req_en_passant_col_1,
  input  logic [1:0]             req_flag_0,
  input  logic [1:0]             req_flag_1,
  input  logic [EVAL_WIDTH-1:0]  req_eval_0,
  input  logic [EVAL_WIDTH-1:0]  req_eval_1,
  input  logic [7:0]             req_depth_0,
  input  logic [7:0]             req_depth_1,
  output logic [1:0]             rsp_valid,
  output logic                   rsp_hit,
  output logic                   rsp_timeout,
  output logic [31:0]            rsp_hash,
  output logic [EVAL_WIDTH-1:0]  rsp_eval,
  output logic [7:0]             rsp_depth,
  output logic [1:0]             rsp_flag,
  output logic                   entry_lookup_out,
  output logic                   entry_store_out,
  output logic [BOARD_WIDTH-1:0] board_out,
  output logic                   white_to_move_out,
  output logic [3:0]             castle_mask_out,
  output logic [3:0]             en_passant_col_out,
  output logic [1:0]             flag_out,
  output logic [EVAL_WIDTH-1:0]  eval_out,
  output logic [7:0]             depth_out,
  input  logic                   trans_busy_in,
  input  logic                   trans_entry_valid_in,
  input  logic [31:0]            trans_hash_in,
  input  logic [EVAL_WIDTH-1:0]  trans_eval_in,
  input  logic [7:0]             trans_depth_in,
  input  logic [1:0]             trans_flag_in,
  input  logic                   stats_clear,
  output logic [31:0]            lookup_count,
  output logic [31:0]            hit_count,
  output logic [31:0]            store_count,
  output logic [31:0]            timeout_count
);
  localparam int FW = BOARD_WIDTH + EVAL_WIDTH + 19;
  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [FW-1:0] fld_q, fld_d;
  logic owner_q, owner_d, store_q, store_d, last_q, last_d, tmo_q, tmo_d, hit_q, hit_d;
  logic [31:0] hash_q, hash_d;
  logic [EVAL_WIDTH-1:0] eval_q, eval_d;
  logic [7:0] depth_q, depth_d;
  logic [1:0] flag_q, flag_d;
  logic [31:0] lk_q, lk_d, hc_q, hc_d, sc_q, sc_d, tc_q, tc_d;
  logic grant, accept, resp;
  always_comb begin
    grant = &req_valid ? ~last_q : req_valid[1];
    accept = state_q == IDLE && |req_valid;
    resp = state_q == RESPOND;
    req_ready = accept ? {grant, ~grant} : 2'b00;
    state_d = state_q;
    timer_d = timer_q;
    fld_d = fld_q;
    owner_d = owner_q;
    store_d = store_q;
    last_d = last_q;
    tmo_d = tmo_q;
    hit_d = hit_q;
    hash_d = hash_q;
    eval_d = eval_q;
    depth_d = depth_q;
    flag_d = flag_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ISSUE;
        owner_d = grant;
        last_d = grant;
        store_d = req_store[grant];
        timer_d = '0;
        tmo_d = 1'b0;
        hit_d = 1'b0;
        fld_d = grant ? {req_board_1, req_white_to_move[1], req_castle_mask_1, req_en_passant_col_1,
                         req_flag_1, req_eval_1, req_depth_1}
                      : {req_board_0, req_white_to_move[0], req_castle_mask_0, req_en_passant_col_0,
                         req_flag_0, req_eval_0, req_depth_0};
      end
      // busy wins over an expiring timer in the same cycle
      ISSUE: if (trans_busy_in) state_d = WAIT_DONE;
        else if (timer_q == TW'(ISSUE_TIMEOUT)) begin
          state_d = RESPOND;
          tmo_d = 1'b1;
        end else timer_d = timer_q + 1'b1;
      WAIT_DONE: if (!trans_busy_in) begin
        state_d = RESPOND;
        hit_d = trans_entry_valid_in & ~store_q;
        hash_d = trans_hash_in;
        eval_d = trans_eval_in;
        depth_d = trans_depth_in;
        flag_d = trans_flag_in;
      end
      default: state_d = IDLE;
    endcase
    lk_d = stats_clear ? '0 : lk_q + {31'b0, resp & ~store_q & ~tmo_q};
    hc_d = stats_clear ? '0 : hc_q + {31'b0, resp & hit_q};
    sc_d = stats_clear ? '0 : sc_q + {31'b0, resp & store_q & ~tmo_q};
    tc_d = stats_clear ? '0 : tc_q + {31'b0, resp & tmo_q};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      fld_q <= '0;
      owner_q <= 1'b0;
      store_q <= 1'b0;
      last_q <= 1'b1;
      tmo_q <= 1'b0;
      hit_q <= 1'b0;
      hash_q <= '0;
      eval_q <= '0;
      depth_q <= '0;
      flag_q <= '0;
      lk_q <= '0;
      hc_q <= '0;
      sc_q <= '0;
      tc_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fld_q <= fld_d;
      owner_q <= owner_d;
      store_q <= store_d;
      last_q <= last_d;
      tmo_q <= tmo_d;
      hit_q <= hit_d;
      hash_q <= hash_d;
      eval_q <= eval_d;
      depth_q <= depth_d;
      flag_q <= flag_d;
      lk_q <= lk_d;
      hc_q <= hc_d;
      sc_q <= sc_d;
      tc_q <= tc_d;
    end
  end
  assign {board_out, white_to_move_out, castle_mask_out, en_passant_col_out, flag_out, eval_out, depth_out} = fld_q;
  assign entry_lookup_out = state_q == ISSUE && !store_q;
  assign entry_store_out = state_q == ISSUE && store_q;
  assign rsp_valid = resp ? {owner_q, ~owner_q} : 2'b00;
  assign rsp_hit = resp & hit_q;
  assign rsp_timeout = resp & tmo_q;
  assign rsp_hash = hash_q;
  assign rsp_eval = eval_q;
  assign rsp_depth = depth_q;
  assign rsp_flag = flag_q;
  assign lookup_count = lk_q;
  assign hit_count = hc_q;
  assign store_count = sc_q;
  assign timeout_count = tc_q;
endmodule

// File: tb/tb_trans_arbiter.sv
// tb_trans_arbiter: randomized transactions against a cycle-count and counter model of the arbiter.
module tb_trans_arbiter;
  localparam int BW = 64;
  localparam int EW = 16;
  localparam int T = 15;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_valid = '0, req_ready, req_store = '0, req_white_to_move = '0;
  logic [BW-1:0] req_board_0 = '0, req_board_1 = '0, board_out;
  logic [3:0] req_castle_mask_0 = '0, req_castle_mask_1 = '0, req_en_passant_col_0 = '0, req_en_passant_col_1 = '0;
  logic [1:0] req_flag_0 = '0, req_flag_1 = '0, rsp_valid, rsp_flag, flag_out, trans_flag_in = '0;
  logic [EW-1:0] req_eval_0 = '0, req_eval_1 = '0, rsp_eval, eval_out, trans_eval_in = '0;
  logic [7:0] req_depth_0 = '0, req_depth_1 = '0, rsp_depth, depth_out, trans_depth_in = '0;
  logic rsp_hit, rsp_timeout, entry_lookup_out, entry_store_out, white_to_move_out;
  logic [3:0] castle_mask_out, en_passant_col_out;
  logic [31:0] rsp_hash, trans_hash_in = '0, lookup_count, hit_count, store_count, timeout_count;
  logic trans_busy_in = 1'b0, trans_entry_valid_in = 1'b0, stats_clear = 1'b0;
  int n_cmp = 0, n_bad = 0, last_g = 1;
  logic [31:0] m_lk = '0, m_hit = '0, m_st = '0, m_to = '0;

  trans_arbiter #(.BOARD_WIDTH(BW), .EVAL_WIDTH(EW), .ISSUE_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_board_0(req_board_0), .req_board_1(req_board_1), .req_white_to_move(req_white_to_move),
    .req_castle_mask_0(req_castle_mask_0), .req_castle_mask_1(req_castle_mask_1),
    .req_en_passant_col_0(req_en_passant_col_0), .req_en_passant_col_1(req_en_passant_col_1),
    .req_flag_0(req_flag_0), .req_flag_1(req_flag_1), .req_eval_0(req_eval_0), .req_eval_1(req_eval_1),
    .req_depth_0(req_depth_0), .req_depth_1(req_depth_1), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
    .rsp_timeout(rsp_timeout), .rsp_hash(rsp_hash), .rsp_eval(rsp_eval), .rsp_depth(rsp_depth),
    .rsp_flag(rsp_flag), .entry_lookup_out(entry_lookup_out), .entry_store_out(entry_store_out),
    .board_out(board_out), .white_to_move_out(white_to_move_out), .castle_mask_out(castle_mask_out),
    .en_passant_col_out(en_passant_col_out), .flag_out(flag_out), .eval_out(eval_out), .depth_out(depth_out),
    .trans_busy_in(trans_busy_in), .trans_entry_valid_in(trans_entry_valid_in), .trans_hash_in(trans_hash_in),
    .trans_eval_in(trans_eval_in), .trans_depth_in(trans_depth_in), .trans_flag_in(trans_flag_in),
    .stats_clear(stats_clear), .lookup_count(lookup_count), .hit_count(hit_count),
    .store_count(store_count), .timeout_count(timeout_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_lookup_count"}, lookup_count, m_lk);
    chk({tag, "_hit_count"}, hit_count, m_hit);
    chk({tag, "_store_count"}, store_count, m_st);
    chk({tag, "_timeout_count"}, timeout_count, m_to);
  endtask

  // s: cycles after acceptance that trans raises busy, d: busy length (0 = trans never responds)
  task automatic txn(input logic [1:0] vm, input logic [1:0] stm, input int s, input int d, input bit clr, input int ev);
    int g, lat, hi, exp_lat, exp_hi;
    bit tmo, st, hit, wrong, hold_ok, rdy_ok;
    logic [1:0] gm;
    logic [BW+EW+7:0] held;
    g = (vm == 2'b11) ? 1 - last_g : (vm[1] ? 1 : 0);
    gm = (g == 1) ? 2'b10 : 2'b01;
    st = stm[g];
    tmo = (d == 0);
    req_board_0 = {$urandom, $urandom};
    req_board_1 = {$urandom, $urandom};
    req_eval_0 = EW'($urandom);
    req_eval_1 = EW'($urandom);
    req_depth_0 = 8'($urandom);
    req_depth_1 = 8'($urandom);
    req_white_to_move = 2'($urandom);
    req_castle_mask_0 = 4'($urandom);
    req_castle_mask_1 = 4'($urandom);
    req_flag_0 = 2'($urandom);
    req_flag_1 = 2'($urandom);
    req_store = stm;
    req_valid = vm;
    trans_hash_in = $urandom;
    trans_eval_in = (ev >= 0) ? EW'(ev) : EW'($urandom);
    trans_entry_valid_in = (ev >= 0) ? 1'b1 : 1'($urandom);
    trans_depth_in = 8'($urandom);
    trans_flag_in = 2'($urandom);
    held = g ? {req_board_1, req_eval_1, req_depth_1} : {req_board_0, req_eval_0, req_depth_0};
    #1;
    chk("grant_ready", req_ready, gm);
    @(negedge clk);
    req_valid = vm & ~gm;
    lat = -1;
    hi = 0;
    wrong = 0;
    hold_ok = 1;
    rdy_ok = 1;
    for (int n = 0; n < 60; n++) begin
      trans_busy_in = d > 0 && n >= s && n < s + d;
      #1;
      if (rsp_valid != 2'b00) begin
        lat = n;
        break;
      end
      hi += st ? int'(entry_store_out) : int'(entry_lookup_out);
      wrong |= st ? entry_lookup_out : entry_store_out;
      hold_ok &= {board_out, eval_out, depth_out} === held;
      rdy_ok &= req_ready == 2'b00;
      @(negedge clk);
    end
    exp_lat = tmo ? T + 1 : s + d + 1;
    exp_hi = tmo ? T + 1 : s + 1;
    hit = trans_entry_valid_in & ~st & ~tmo;
    chk("rsp_latency", 64'(lat), 64'(exp_lat));
    chk("strobe_cycles", 64'(hi), 64'(exp_hi));
    chk("wrong_strobe", wrong, 0);
    chk("fields_held", hold_ok, 1);
    chk("no_ready_busy", rdy_ok, 1);
    chk("rsp_owner", rsp_valid, gm);
    chk("rsp_timeout", rsp_timeout, tmo);
    chk("rsp_hit", rsp_hit, hit);
    chk("held_at_rsp", {board_out, eval_out, depth_out}, held);
    if (!tmo) chk("rsp_hash", rsp_hash, trans_hash_in);
    if (!tmo && !st) chk("rsp_eval", rsp_eval, trans_eval_in);
    stats_clear = clr;
    if (clr) {m_lk, m_hit, m_st, m_to} = '0;
    else begin
      if (tmo) m_to++;
      else if (st) m_st++;
      else m_lk++;
      if (hit) m_hit++;
    end
    last_g = g;
    @(negedge clk);
    stats_clear = 1'b0;
    #1;
    chk("rsp_single_pulse", rsp_valid, 0);
    chk_counters("txn");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_strobes", {entry_lookup_out, entry_store_out}, 0);
    chk("reset_board", board_out, 0);
    chk_counters("reset");
    reset = 1'b0;
    @(negedge clk);
    txn(2'b01, 2'b00, 1, 10, 0, 'h123);
    chk("first_rsp_eval", rsp_eval, 'h123);
    for (int i = 0; i < 4; i++) txn(2'b11, 2'($urandom), 1, 3, 0, -1);
    txn(2'b10, 2'b10, 2, 6, 0, -1);
    txn(2'b01, 2'b00, 1, 0, 0, -1);
    txn(2'b01, 2'b00, 0, 4, 0, -1);
    for (int i = 0; i < 40; i++)
      txn(2'($urandom_range(1, 3)), 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 12), $urandom_range(0, 9) == 0, -1);
    txn(2'b01, 2'b00, 1, 20, 0, -1);
    txn(2'b01, 2'b00, 1, 0, 0, -1);
    req_valid = 2'b01;
    req_store = 2'b00;
    trans_busy_in = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk("pre_reset_strobe", entry_lookup_out, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_strobe", {entry_lookup_out, entry_store_out}, 0);
    chk("async_reset_rsp", rsp_valid, 0);
    {m_lk, m_hit, m_st, m_to} = '0;
    last_g = 1;
    chk_counters("async_reset");
    @(negedge clk);
    reset = 1'b0;
    txn(2'b11, 2'b00, 1, 5, 0, -1);
    txn(2'b11, 2'b01, 1, 5, 1, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
